aes_key_sched: RTL and testbench
================================

# aes_key_sched

Round-key generator and store that sits directly upstream of the encrypt/decrypt core. It accepts a 128/192/256-bit cipher key and expands it into 4·(Nr+1) 32-bit words at one word per cycle. It answers the core's round address combinationally with a 129-bit `{valid, round_key}` bus. Because each round key is flagged valid as soon as its four words exist, encryption can start while expansion is still running; decryption naturally waits for round Nr.

## Interface
- No parameters; sizes come from the shared package and `AES_KEY256_EN`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_in` in 256: cipher key; key byte k at [8k+7:8k]. Bytes above Nk·4 are ignored.
- `key_len` in 2: 00 = 128, 01 = 192, 10 = 256, 11 = illegal.
- `key_load` in 1: one-cycle load strobe.
- `Addr` in 4: round-key index requested by the core.
- `Key` out 129: bit 128 = valid for `Addr`; [127:0] = round key `Addr`.
- `Nr` out 4: round count of the loaded key, 10/12/14; drives the core's `Nr`.
- `busy` out 1: expansion in progress.
- `keys_ready` out 1: all round keys valid.

## Operation
- **FSM states:**
  - IDLE: reset, or no key loaded.
  - EXPAND: words are being generated.
  - READY: all words present.
- **Load.** A legal `key_load` is accepted in any state.
  - On that edge, words w[0..Nk-1] are written from `key_in` (Nk = 4/6/8).
  - `wcnt` is set to Nk, `Nr` to 10/12/14, `rcon` to 0x01, the mod-Nk phase counter `j` to 0, and the state goes to EXPAND.
  - A load in EXPAND or READY abandons the old schedule. Valid flags are recomputed from the new `wcnt` on the same edge.
- **Illegal loads.** `key_len` = 11, or 10 without `AES_KEY256_EN`, is ignored with no state change.
- **Expand step.** One step per cycle in EXPAND, for i = `wcnt`:
  - `temp` = w[i-1].
  - If j == 0: `temp` = SubWord(RotWord(`temp`)) ^ {24'h0, `rcon`}.
  - Else if Nk == 8 and j == 4: `temp` = SubWord(`temp`).
  - w[i] = w[i-Nk] ^ `temp`. Then `wcnt`++ and j = (j+1) mod Nk.
  - After each use of `rcon` at j == 0, `rcon` = xtime(`rcon`) (0x80 becomes 0x1b).
- **Word byte order.** FIPS byte a0 sits at bits [7:0]. RotWord is a right rotate by 8 bits: {a0,a3,a2,a1} as [31:0]. `rcon` XORs into [7:0].
- **Completion.** When `wcnt` reaches W = 4·(Nr+1) (44/52/60), the state goes to READY.
- **Read path (combinational).**
  - `Key`[127:0] = {w[4A+3], w[4A+2], w[4A+1], w[4A]}.
  - `Key`[128] = (A ≤ Nr) && (`wcnt` ≥ 4A+4).
  - For A > Nr, or in IDLE: `Key` = 129'h0.
- **System rule.** The system issues `key_load` only while the core's `Core_Full` is low. The block does not check this.

## Timing
- **Reset values:** `Key` = 0 (word array cleared), `Nr` = 0, `busy` = 0, `keys_ready` = 0, state IDLE.
- **Load edge.** Counted as edge 0. From the cycle after it, `busy` = 1 and round 0 is valid.
- **Round r valid** from the cycle after edge (4r+4-Nk), with a minimum of edge 0.
- **`keys_ready`** rises, and `busy` falls, after edge W-Nk: 40 / 46 / 52 cycles for 128/192/256.
- **Read latency.** `Addr` to `Key` is zero-cycle (same cycle). The core samples `Key` on its own clock edge.
- **Load during EXPAND.** The new load wins; no word of the old key remains flagged valid afterwards.
- **Reset mid-expansion** returns to IDLE with all outputs at their reset values.

## Configuration
- `AES_KEY256_EN` defined:
  - 60-word array.
  - `key_len` = 10 is legal.
  - The j == 4 SubWord path is present.
- `AES_KEY256_EN` undefined:
  - 52-word array.
  - `key_len` = 10 is treated as illegal (load ignored).
  - The Nk == 8 logic is removed.
  - `key_in`[255:192] is unused.

## Structure
- **Package `aes_pkg`:**
  - Key-length encodings.
  - NR_128/192/256 and NK_*.
  - Word counts 44/52/60.
  - MAX_WORDS (macro-dependent).
  - RCON_INIT = 8'h01.
  - An xtime function shared with the core's mix logic.
- **Sub-module `aes_sub_word`:** 32-bit SubWord built from four existing `aes_sbox` instances. The FSM, counters and word array stay in `aes_key_sched`.

## Test plan
- **FIPS-197 A.1, 128-bit** (key bytes 2b7e1516 28aed2a6 abf71588 09cf4f3c). Required:
  - Round 10 word 3 (w43) = b6630ca6.
  - `Key`[31:0] for Addr 10 holds bytes d0,14,f9,a8 with d0 at [7:0].
  - `keys_ready` rises 40 cycles after load.
- **192-bit key** (8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b). Required: w51 = 01002202, `Nr` = 12, ready after 46 cycles.
- **256-bit key** (603deb10 … 0914dff4, `AES_KEY256_EN` on). Required: w59 = 706c631b. With the macro off, the same load leaves the state IDLE.
- **Early validity.**
  - 128-bit load: `Key`[128] for Addr 0 is 1 the cycle after load; for Addr 1 it is 0 until 4 edges later.
  - Addr 11 with `Nr` = 10: `Key` = 0.
- **Reload at cycle 20 of a 128-bit expansion** with a 192-bit key. Required: round 2 valid flag drops, final keys match the 192-bit vector, ready 46 cycles after the second load.
- **`rst_n` low mid-EXPAND.** Required: all outputs 0 asynchronously; a subsequent load expands correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the key schedule and the cipher core.
// Configuration macro: AES_KEY256_EN enables 256-bit keys (60-word store).
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128 = 2'b00;
  localparam logic [1:0] KEY_LEN_192 = 2'b01;
  localparam logic [1:0] KEY_LEN_256 = 2'b10;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;

  localparam logic [5:0] WORDS_128 = 6'd44;
  localparam logic [5:0] WORDS_192 = 6'd52;
  localparam logic [5:0] WORDS_256 = 6'd60;

`ifdef AES_KEY256_EN
  localparam int MAX_WORDS = 60;
  localparam int NK_MAX    = 8;
`else
  localparam int MAX_WORDS = 52;
  localparam int NK_MAX    = 6;
`endif

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_sub_word.sv
// SubWord: byte-wise S-box over a 32-bit schedule word.
module aes_sub_word (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte (word_in[8*b +: 8]),
      .out_byte(word_out[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) inverse (as a^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  logic [7:0] p2, p4, p8, p16, p32, p64, p128, inv;

  // Inverse via square chain (zero maps to zero), then affine transform.
  always_comb begin
    p2   = gf_mul(in_byte, in_byte);
    p4   = gf_mul(p2, p2);
    p8   = gf_mul(p4, p4);
    p16  = gf_mul(p8, p8);
    p32  = gf_mul(p16, p16);
    p64  = gf_mul(p32, p32);
    p128 = gf_mul(p64, p64);
    inv  = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                  gf_mul(gf_mul(p32, p64), p128));
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_sched.sv
// AES key expansion and round-key store, one word per cycle, with a
// combinational round-key read port that flags keys valid as soon as all
// four words exist. Configuration macro: AES_KEY256_EN (256-bit keys).
//
//   state     | meaning
//   ----------+------------------------------------------
//   ST_IDLE   | reset, or no key loaded
//   ST_EXPAND | words are being generated
//   ST_READY  | all words of the schedule present
module aes_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  input  logic         key_load,
  input  logic [3:0]   Addr,
  output logic [128:0] Key,
  output logic [3:0]   Nr,
  output logic         busy,
  output logic         keys_ready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  wcnt_q, wcnt_d;
  logic [3:0]  nr_q, nr_d;
  logic [3:0]  nk_q, nk_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [2:0]  j_q, j_d;
  logic [31:0] w_q [MAX_WORDS];
  logic [31:0] w_d [MAX_WORDS];

  logic        load_acc;
  logic [3:0]  ld_nk, ld_nr;
  logic [5:0]  words_total;
  logic [31:0] prev_word, back_word, sw_in, sw_out, temp, new_word;
  logic [5:0]  base;

`ifndef AES_KEY256_EN
  logic unused_key_hi;
  assign unused_key_hi = ^key_in[255:192];
`endif

  function automatic logic [31:0] rd_word(input logic [5:0] idx);
    if (idx < 6'(MAX_WORDS)) return w_q[idx];
    return 32'h0;
  endfunction

  // Decode key length; illegal encodings never produce an accepted load.
  always_comb begin
    load_acc = 1'b0;
    ld_nk    = NK_128;
    ld_nr    = NR_128;
    case (key_len)
      KEY_LEN_128: begin load_acc = key_load; ld_nk = NK_128; ld_nr = NR_128; end
      KEY_LEN_192: begin load_acc = key_load; ld_nk = NK_192; ld_nr = NR_192; end
`ifdef AES_KEY256_EN
      KEY_LEN_256: begin load_acc = key_load; ld_nk = NK_256; ld_nr = NR_256; end
`endif
      default: ;
    endcase
  end

  // Schedule length for the currently loaded key.
  always_comb begin
    case (nr_q)
      NR_128:  words_total = WORDS_128;
      NR_192:  words_total = WORDS_192;
      default: words_total = WORDS_256;
    endcase
  end

  assign prev_word = rd_word(wcnt_q - 6'd1);
  assign back_word = rd_word(wcnt_q - {2'b00, nk_q});
  assign sw_in     = (j_q == 3'd0) ? {prev_word[7:0], prev_word[31:8]} : prev_word;

  aes_sub_word u_sub_word (
    .word_in (sw_in),
    .word_out(sw_out)
  );

  // Next schedule word w[wcnt] from w[wcnt-1] and w[wcnt-Nk].
  always_comb begin
    temp = prev_word;
    if (j_q == 3'd0) begin
      temp = sw_out ^ {24'h0, rcon_q};
    end
`ifdef AES_KEY256_EN
    else if (nk_q == NK_256 && j_q == 3'd4) begin
      temp = sw_out;
    end
`endif
    new_word = back_word ^ temp;
  end

  // Load / expand / complete sequencing.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    nr_d    = nr_q;
    nk_d    = nk_q;
    rcon_d  = rcon_q;
    j_d     = j_q;
    w_d     = w_q;
    if (load_acc) begin
      for (int k = 0; k < NK_MAX; k++) begin
        if (4'(k) < ld_nk) w_d[k] = key_in[32*k +: 32];
      end
      wcnt_d  = {2'b00, ld_nk};
      nr_d    = ld_nr;
      nk_d    = ld_nk;
      rcon_d  = RCON_INIT;
      j_d     = 3'd0;
      state_d = ST_EXPAND;
    end else if (state_q == ST_EXPAND) begin
      if (wcnt_q < 6'(MAX_WORDS)) w_d[wcnt_q] = new_word;
      wcnt_d = wcnt_q + 6'd1;
      if ({1'b0, j_q} == nk_q - 4'd1) j_d = 3'd0;
      else                           j_d = j_q + 3'd1;
      if (j_q == 3'd0) rcon_d = xtime(rcon_q);
      if (wcnt_q + 6'd1 == words_total) state_d = ST_READY;
    end
  end

  // State, counters and word store; reset clears every word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 6'd0;
      nr_q    <= 4'd0;
      nk_q    <= 4'd0;
      rcon_q  <= 8'd0;
      j_q     <= 3'd0;
      for (int k = 0; k < MAX_WORDS; k++) w_q[k] <= 32'h0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      nr_q    <= nr_d;
      nk_q    <= nk_d;
      rcon_q  <= rcon_d;
      j_q     <= j_d;
      w_q     <= w_d;
    end
  end

  // Combinational round-key read port with early-valid flag.
  always_comb begin
    Key  = '0;
    base = {Addr, 2'b00};
    if (state_q != ST_IDLE && Addr <= nr_q) begin
      Key[31:0]   = rd_word(base);
      Key[63:32]  = rd_word(base + 6'd1);
      Key[95:64]  = rd_word(base + 6'd2);
      Key[127:96] = rd_word(base + 6'd3);
      Key[128]    = (wcnt_q >= base + 6'd4);
    end
  end

  assign Nr         = nr_q;
  assign busy       = (state_q == ST_EXPAND);
  assign keys_ready = (state_q == ST_READY);

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched: FIPS-197 vectors plus random keys
// against a byte-level key expansion model.
module tb_aes_key_sched;

  logic         clk;
  logic         rst_n;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic         key_load;
  logic [3:0]   Addr;
  logic [128:0] Key;
  logic [3:0]   Nr;
  logic         busy;
  logic         keys_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sb [256];
  logic [31:0] m_w [60];
  int          m_nr;
  int          m_nk;

  localparam logic [255:0] K128_BE = 256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
  localparam logic [255:0] K192_BE = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b_0000000000000000;
  localparam logic [255:0] K256_BE = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_len   (key_len),
    .key_load  (key_load),
    .Addr      (Addr),
    .Key       (Key),
    .Nr        (Nr),
    .busy      (busy),
    .keys_ready(keys_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [255:0] be2le(input logic [255:0] be);
    logic [255:0] le;
    for (int k = 0; k < 32; k++) le[8*k +: 8] = be[255 - 8*k -: 8];
    return le;
  endfunction

  // FIPS-197 KeyExpansion over bytes; word i holds byte a0 at [7:0].
  function automatic void model_expand(input logic [255:0] key, input int nk);
    logic [7:0] t [4];
    logic [7:0] t0, rc;
    logic [31:0] pw;
    int nw;
    m_nk = nk;
    m_nr = nk + 6;
    nw   = 4 * (m_nr + 1);
    for (int i = 0; i < 60; i++) m_w[i] = 32'h0;
    for (int i = 0; i < nk; i++) m_w[i] = key[32*i +: 32];
    for (int i = nk; i < nw; i++) begin
      pw = m_w[i-1];
      for (int b = 0; b < 4; b++) t[b] = pw[8*b +: 8];
      if (i % nk == 0) begin
        t0 = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = t0;
        for (int b = 0; b < 4; b++) t[b] = sb[t[b]];
        rc = 8'h01;
        for (int r = 1; r < i / nk; r++) rc = gmul(rc, 8'h02);
        t[0] = t[0] ^ rc;
      end else if (nk == 8 && i % nk == 4) begin
        for (int b = 0; b < 4; b++) t[b] = sb[t[b]];
      end
      m_w[i] = m_w[i-nk] ^ {t[3], t[2], t[1], t[0]};
    end
  endfunction

  // Drive a load strobe; returns one step after the load edge (edge 0).
  task automatic start_load(input logic [255:0] k, input logic [1:0] len);
    key_in   = k;
    key_len  = len;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  // Follow an expansion from edge start_n to completion, then audit all rounds.
  task automatic run_expansion(input string tag, input int start_n, input int exp_cycles);
    int n;
    int a;
    logic exp_v;
    n = start_n;
    while (!keys_ready && n < 200) begin
      a = $urandom_range(0, 15);
      Addr = 4'(a);
      #1;
      exp_v = (a <= m_nr) && (n >= 4*a + 4 - m_nk);
      checks++;
      if (Key[128] !== exp_v) begin
        errors++;
        $display("FAIL %s_valid edge %0d addr %0d: got %b expected %b", tag, n, a, Key[128], exp_v);
      end
      if (exp_v) begin
        checks++;
        if (Key[127:0] !== {m_w[4*a+3], m_w[4*a+2], m_w[4*a+1], m_w[4*a]}) begin
          errors++;
          $display("FAIL %s_early_data addr %0d: got %h", tag, a, Key[127:0]);
        end
      end else if (a > m_nr) begin
        checks++;
        if (Key !== 129'h0) begin
          errors++;
          $display("FAIL %s_out_of_range addr %0d: got %h expected 0", tag, a, Key);
        end
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy edge %0d: got %b expected 1", tag, n, busy);
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != exp_cycles) begin
      errors++;
      $display("FAIL %s_ready_latency: got %0d expected %0d", tag, n, exp_cycles);
    end
    checks++;
    if (busy !== 1'b0 || Nr !== 4'(m_nr)) begin
      errors++;
      $display("FAIL %s_final_status: busy %b Nr %0d expected busy 0 Nr %0d", tag, busy, Nr, m_nr);
    end
    for (int r = 0; r <= m_nr; r++) begin
      Addr = 4'(r);
      #1;
      checks++;
      if (Key !== {1'b1, m_w[4*r+3], m_w[4*r+2], m_w[4*r+1], m_w[4*r]}) begin
        errors++;
        $display("FAIL %s_round %0d: got %h expected %h", tag, r, Key,
                 {1'b1, m_w[4*r+3], m_w[4*r+2], m_w[4*r+1], m_w[4*r]});
      end
    end
    Addr = 4'(m_nr + 1);
    #1;
    checks++;
    if (Key !== 129'h0) begin
      errors++;
      $display("FAIL %s_addr_above_nr: got %h expected 0", tag, Key);
    end
  endtask

  task automatic test_reset();
    Addr = 4'd0;
    #1;
    checks++;
    if (Key !== 129'h0 || Nr !== 4'd0 || busy !== 1'b0 || keys_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: Key %h Nr %0d busy %b ready %b expected all 0", Key, Nr, busy, keys_ready);
    end
    Addr = 4'd5;
    #1;
    checks++;
    if (Key !== 129'h0) begin
      errors++;
      $display("FAIL reset_key_addr5: got %h expected 0", Key);
    end
  endtask

  task automatic test_fips128();
    model_expand(be2le(K128_BE), 4);
    start_load(be2le(K128_BE), 2'b00);
    Addr = 4'd0;
    #1;
    checks++;
    if (Key[128] !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL f128_round0_valid: valid %b busy %b expected 1 1", Key[128], busy);
    end
    for (int e = 0; e <= 4; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      Addr = 4'd1;
      #1;
      checks++;
      if (Key[128] !== (e >= 4)) begin
        errors++;
        $display("FAIL f128_round1_valid edge %0d: got %b expected %b", e, Key[128], (e >= 4));
      end
    end
    run_expansion("f128", 4, 40);
    Addr = 4'd10;
    #1;
    checks++;
    if (Key[127:96] !== 32'ha60c63b6) begin
      errors++;
      $display("FAIL f128_w43: got %h expected a60c63b6", Key[127:96]);
    end
    checks++;
    if (Key[31:0] !== 32'ha8f914d0) begin
      errors++;
      $display("FAIL f128_w40_bytes: got %h expected a8f914d0", Key[31:0]);
    end
    Addr = 4'd11;
    #1;
    checks++;
    if (Nr !== 4'd10 || Key !== 129'h0) begin
      errors++;
      $display("FAIL f128_addr11: Nr %0d Key %h expected 10 and 0", Nr, Key);
    end
  endtask

  task automatic test_fips192();
    model_expand(be2le(K192_BE), 6);
    start_load(be2le(K192_BE), 2'b01);
    run_expansion("f192", 0, 46);
    Addr = 4'd12;
    #1;
    checks++;
    if (Key[127:96] !== 32'h02220001 || Nr !== 4'd12) begin
      errors++;
      $display("FAIL f192_w51: got %h Nr %0d expected 02220001 Nr 12", Key[127:96], Nr);
    end
  endtask

  task automatic test_key256();
`ifdef AES_KEY256_EN
    model_expand(be2le(K256_BE), 8);
    start_load(be2le(K256_BE), 2'b10);
    run_expansion("f256", 0, 52);
    Addr = 4'd14;
    #1;
    checks++;
    if (Key[127:96] !== 32'h1b636c70 || Nr !== 4'd14) begin
      errors++;
      $display("FAIL f256_w59: got %h Nr %0d expected 1b636c70 Nr 14", Key[127:96], Nr);
    end
`else
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    start_load(be2le(K256_BE), 2'b10);
    for (int e = 0; e < 3; e++) begin
      Addr = 4'd0;
      #1;
      checks++;
      if (busy !== 1'b0 || keys_ready !== 1'b0 || Nr !== 4'd0 || Key !== 129'h0) begin
        errors++;
        $display("FAIL k256_disabled_idle: busy %b ready %b Nr %0d Key %h expected all 0",
                 busy, keys_ready, Nr, Key);
      end
      @(posedge clk); #1;
    end
`endif
  endtask

  task automatic test_random();
    logic [255:0] k;
    int sel, nk;
    for (int it = 0; it < 4; it++) begin
      for (int b = 0; b < 8; b++) k[32*b +: 32] = $urandom;
`ifdef AES_KEY256_EN
      sel = $urandom_range(0, 2);
`else
      sel = $urandom_range(0, 1);
`endif
      nk = 4 + 2 * sel;
      model_expand(k, nk);
      start_load(k, 2'(sel));
      run_expansion("rand", 0, 4 * (nk + 7) - nk);
    end
  endtask

  task automatic test_illegal();
    logic [255:0] k;
    int nr_before;
    nr_before = m_nr;
    for (int b = 0; b < 8; b++) k[32*b +: 32] = $urandom;
    start_load(k, 2'b11);
`ifndef AES_KEY256_EN
    start_load(k, 2'b10);
`endif
    repeat (3) @(posedge clk);
    #1;
    Addr = 4'(nr_before);
    #1;
    checks++;
    if (keys_ready !== 1'b1 || busy !== 1'b0 || Nr !== 4'(nr_before)) begin
      errors++;
      $display("FAIL illegal_status: ready %b busy %b Nr %0d expected 1 0 %0d", keys_ready, busy, Nr, nr_before);
    end
    checks++;
    if (Key !== {1'b1, m_w[4*nr_before+3], m_w[4*nr_before+2], m_w[4*nr_before+1], m_w[4*nr_before]}) begin
      errors++;
      $display("FAIL illegal_key_kept: got %h", Key);
    end
  endtask

  task automatic test_reload();
    model_expand(be2le(K128_BE), 4);
    start_load(be2le(K128_BE), 2'b00);
    repeat (20) @(posedge clk);
    #1;
    Addr = 4'd2;
    #1;
    checks++;
    if (Key[128] !== 1'b1) begin
      errors++;
      $display("FAIL reload_round2_before: got %b expected 1", Key[128]);
    end
    model_expand(be2le(K192_BE), 6);
    start_load(be2le(K192_BE), 2'b01);
    Addr = 4'd2;
    #1;
    checks++;
    if (Key[128] !== 1'b0 || Nr !== 4'd12) begin
      errors++;
      $display("FAIL reload_round2_drop: valid %b Nr %0d expected 0 12", Key[128], Nr);
    end
    run_expansion("reload", 0, 46);
    Addr = 4'd12;
    #1;
    checks++;
    if (Key[127:96] !== 32'h02220001) begin
      errors++;
      $display("FAIL reload_w51: got %h expected 02220001", Key[127:96]);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k;
    for (int b = 0; b < 8; b++) k[32*b +: 32] = $urandom;
    model_expand(k, 4);
    start_load(k, 2'b00);
    repeat (15) @(posedge clk);
    Addr = 4'd0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (Key !== 129'h0 || Nr !== 4'd0 || busy !== 1'b0 || keys_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: Key %h Nr %0d busy %b ready %b expected all 0", Key, Nr, busy, keys_ready);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (Key !== 129'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle_after: Key %h busy %b expected 0 0", Key, busy);
    end
    for (int b = 0; b < 8; b++) k[32*b +: 32] = $urandom;
    model_expand(k, 6);
    start_load(k, 2'b01);
    run_expansion("post_reset", 0, 46);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    key_in   = '0;
    key_len  = 2'b00;
    key_load = 1'b0;
    Addr     = 4'd0;
    build_sbox();
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_fips128();
    test_fips192();
    test_key256();
    test_random();
    test_illegal();
    test_reload();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
